muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with HI/LO result registers.
// Runs one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_isDiv;
   logic [4:0]  r_cnt;
   logic [31:0] r_acc;
   logic [31:0] r_q;
   logic [31:0] r_b;
   logic        r_negLo;
   logic        r_negHi;
   logic        r_divZero;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_isSigned;
   logic        w_aNeg;
   logic        w_bNeg;
   logic [31:0] w_aMag;
   logic [31:0] w_bMag;
   logic [32:0] w_mulSum;
   logic [32:0] w_divSh;
   logic        w_divOk;
   logic [31:0] w_divSub;
   logic [63:0] w_prod;
   logic [63:0] w_prodFix;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_resHi;
   logic [31:0] w_resLo;

   // Signed ops iterate on magnitudes; the signs are reapplied in FIX.
   assign w_isSigned = ~op[0];
   assign w_aNeg     = w_isSigned & rs_data[31];
   assign w_bNeg     = w_isSigned & rt_data[31];
   assign w_aMag     = w_aNeg ? (32'd0 - rs_data) : rs_data;
   assign w_bMag     = w_bNeg ? (32'd0 - rt_data) : rt_data;

   // r_q holds the multiplier (shifted out low end first) or the dividend (high end first).
   assign w_mulSum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
   assign w_divSh    = {r_acc, r_q[31]};
   assign w_divOk    = (w_divSh >= {1'b0, r_b});
   assign w_divSub   = w_divSh[31:0] - r_b;

   assign w_prod     = {r_acc, r_q};
   assign w_prodFix  = r_negLo ? (64'd0 - w_prod) : w_prod;
   // A zero divisor yields an all-ones quotient; the remainder naturally comes back as rs_data.
   assign w_quo      = r_divZero ? 32'hFFFF_FFFF : (r_negLo ? (32'd0 - r_q) : r_q);
   assign w_rem      = r_negHi ? (32'd0 - r_acc) : r_acc;
   assign w_resHi    = r_isDiv ? w_rem : w_prodFix[63:32];
   assign w_resLo    = r_isDiv ? w_quo : w_prodFix[31:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_isDiv   <= 1'b0;
         r_cnt     <= 5'd0;
         r_acc     <= 32'd0;
         r_q       <= 32'd0;
         r_b       <= 32'd0;
         r_negLo   <= 1'b0;
         r_negHi   <= 1'b0;
         r_divZero <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state   <= RUN;
                     r_busy    <= 1'b1;
                     r_isDiv   <= op[1];
                     r_cnt     <= 5'd0;
                     r_acc     <= 32'd0;
                     r_q       <= w_aMag;
                     r_b       <= w_bMag;
                     r_negLo   <= w_aNeg ^ w_bNeg;
                     r_negHi   <= w_aNeg;
                     r_divZero <= (rt_data == 32'd0);
                  end else begin
                     if (mthi) r_hi <= rs_data;
                     if (mtlo) r_lo <= rs_data;
                  end
               end
               RUN: begin
                  if (r_isDiv) begin
                     r_acc <= w_divOk ? w_divSub : w_divSh[31:0];
                     r_q   <= {r_q[30:0], w_divOk};
                  end else begin
                     r_acc <= w_mulSum[32:1];
                     r_q   <= {w_mulSum[0], r_q[31:1]};
                  end
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) r_state <= FIX;
               end
               FIX: begin
                  r_hi    <= w_resHi;
                  r_lo    <= w_resLo;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
